// File: rtl/kws_feature_loader_if.sv
// rtl/kws_feature_loader_if.sv - Wishbone slave and feature stream bundle for kws_feature_loader
interface kws_feature_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;
    logic        overflow;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, out_ready,
        output wbs_ack_o, wbs_dat_o, out_data, out_addr, out_valid, frame_done, overflow
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, out_ready,
        input  wbs_ack_o, wbs_dat_o, out_data, out_addr, out_valid, frame_done, overflow
    );
endinterface

// File: rtl/kws_feature_loader.sv
// rtl/kws_feature_loader.sv - Ping-pong MFCC frame buffer between the Wishbone host and cmvn
module kws_feature_loader #(
    parameter int          FEAT_DIM  = 20,
    parameter logic [7:0]  FEAT_BASE = 8'h40,
    parameter logic [7:0]  CTRL_ADDR = 8'h60,
    parameter logic [7:0]  STAT_ADDR = 8'h61
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    kws_feature_loader_if.slave bus
);
    localparam logic [7:0] LP_DIM  = 8'(FEAT_DIM);
    localparam logic [4:0] LP_LAST = 5'(FEAT_DIM - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_wr_bank, r_rd_bank;
    logic [1:0]  r_full, w_full_nxt;
    logic [4:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_frame_cnt;
    logic        r_ovf;
    logic [31:0] r_mem [2][FEAT_DIM];

    logic [7:0]  w_word_adr, w_feat_off;
    logic [4:0]  w_k;
    logic        w_is_feat, w_is_ctrl, w_is_stat, w_k_ok, w_hit, w_acc, w_wr, w_rd;
    logic        w_feat_wr, w_wr_full, w_mem_we, w_flush, w_commit, w_commit_ok, w_clr_ovf;
    logic        w_ovf_evt, w_drain, w_busy;
    logic [31:0] w_rdata;
    logic        w_unused_adr;

    assign w_word_adr   = bus.wbs_adr_i[9:2];
    assign w_unused_adr = &{1'b0, bus.wbs_adr_i[31:10], bus.wbs_adr_i[1:0]};
    assign w_feat_off   = w_word_adr - FEAT_BASE;
    assign w_k          = w_feat_off[4:0];
    assign w_is_feat    = (w_feat_off < 8'd32);
    assign w_is_ctrl    = (w_word_adr == CTRL_ADDR);
    assign w_is_stat    = (w_word_adr == STAT_ADDR);
    assign w_k_ok       = w_is_feat && (w_feat_off < LP_DIM);
    assign w_hit        = bus.wbs_cyc_i & bus.wbs_stb_i & (w_is_feat | w_is_ctrl | w_is_stat);

    // Side effects fire only on the edge that raises ack, so each transfer acts once.
    assign w_acc        = w_hit & ~r_ack;
    assign w_wr         = w_acc & bus.wbs_we_i;
    assign w_rd         = w_acc & ~bus.wbs_we_i;

    assign w_wr_full    = r_full[r_wr_bank];
    assign w_feat_wr    = w_wr & w_k_ok;
    assign w_mem_we     = w_feat_wr & ~w_wr_full;
    assign w_flush      = w_wr & w_is_ctrl & bus.wbs_dat_i[1];
    assign w_commit     = w_wr & w_is_ctrl & bus.wbs_dat_i[0] & ~bus.wbs_dat_i[1];
    assign w_clr_ovf    = w_wr & w_is_ctrl & bus.wbs_dat_i[2];
    assign w_commit_ok  = w_commit & ~w_wr_full;
    assign w_ovf_evt    = (w_feat_wr | w_commit) & w_wr_full;
    assign w_busy       = (r_state == S_STREAM);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_drain     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = S_STREAM;
                    w_idx_nxt   = 5'd0;
                end
            end
            S_STREAM: begin
                if (bus.out_ready) begin
                    if (r_idx == LP_LAST) begin
                        w_drain     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 5'd0;
            w_drain     = 1'b0;
        end
    end

    // Drain and commit always address different banks, so both updates can land together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_drain)
            w_full_nxt[r_rd_bank] = 1'b0;
        if (w_commit_ok)
            w_full_nxt[r_wr_bank] = 1'b1;
        if (w_flush)
            w_full_nxt = 2'b00;
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_stat)
            w_rdata = {16'd0, r_frame_cnt, 3'd0, w_busy, r_ovf, r_full[1], r_full[0], r_wr_bank};
        else if (w_k_ok)
            w_rdata = r_mem[r_wr_bank][w_k];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b0;
            r_dat       <= 32'd0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_idx       <= 5'd0;
            r_frame_cnt <= 8'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_hit & ~r_ack;
            r_dat       <= w_rd ? w_rdata : 32'd0;
            r_full      <= w_full_nxt;
            r_idx       <= w_idx_nxt;
            r_wr_bank   <= w_flush ? 1'b0 : (w_commit_ok ? ~r_wr_bank : r_wr_bank);
            r_rd_bank   <= w_flush ? 1'b0 : (w_drain ? ~r_rd_bank : r_rd_bank);
            r_frame_cnt <= w_drain ? r_frame_cnt + 8'd1 : r_frame_cnt;
            r_ovf       <= w_ovf_evt ? 1'b1 : (w_clr_ovf ? 1'b0 : r_ovf);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wbs_sel_i[b])
                    r_mem[r_wr_bank][w_k][8*b +: 8] <= bus.wbs_dat_i[8*b +: 8];
            end
        end
    end

    assign bus.wbs_ack_o  = r_ack;
    assign bus.wbs_dat_o  = r_dat;
    assign bus.out_valid  = w_busy;
    assign bus.out_data   = w_busy ? r_mem[r_rd_bank][r_idx] : 32'd0;
    assign bus.out_addr   = w_busy ? r_idx : 5'd0;
    assign bus.frame_done = w_drain;
    assign bus.overflow   = r_ovf;
endmodule
